// File: rtl/conv_window_feeder.sv
// Producer side of the conv MAC stream: turns a raster pixel stream into 3x3 window bursts.
// Two shift-register line buffers supply the upper rows. Only one window is in flight at a time.
module conv_window_feeder #(
    parameter int bits  = 16,
    parameter int img_w = 28,
    parameter int img_h = 28,
    parameter int cnt_w = 5
) (
    input  logic                     clk_in,
    input  logic                     rst_n,
    input  logic signed [bits-1:0]   pix_in,
    input  logic                     pix_valid,
    output logic                     pix_ready,
    input  logic                     w_wr_en,
    input  logic [3:0]               w_addr,
    input  logic [2*bits-1:0]        w_data,
    output logic signed [bits-1:0]   conv_data,
    output logic signed [bits-1:0]   conv_weight,
    output logic signed [2*bits-1:0] conv_bias,
    output logic                     conv_start,
    input  logic                     conv_ready,
    output logic [cnt_w-1:0]         win_row,
    output logic [cnt_w-1:0]         win_col,
    output logic                     frame_done
);
    localparam int filter_size = 9;

    typedef enum logic [1:0] {S_FILL, S_EMIT, S_WAIT} state_t;

    state_t                   state_q;
    logic [3:0]               k_q;
    logic [cnt_w-1:0]         row_q, col_q, row_d, col_d;
    logic [cnt_w-1:0]         win_row_q, win_col_q;
    logic                     last_q, pix_ready_q, frame_done_q;
    logic signed [bits-1:0]   lb0_q [img_w];
    logic signed [bits-1:0]   lb1_q [img_w];
    logic signed [bits-1:0]   win_q [filter_size];
    logic signed [bits-1:0]   w_q [filter_size];
    logic signed [2*bits-1:0] bias_q;
    logic signed [bits-1:0]   new_col [3];
    logic                     accept, col_wrap, row_wrap, win_done;

    assign accept   = (state_q == S_FILL) && pix_valid && pix_ready_q;
    assign col_wrap = (col_q == cnt_w'(img_w - 1));
    assign row_wrap = (row_q == cnt_w'(img_h - 1));
    assign win_done = (row_q >= cnt_w'(2)) && (col_q >= cnt_w'(2));
    assign col_d    = col_wrap ? '0 : col_q + cnt_w'(1);
    assign row_d    = !col_wrap ? row_q : (row_wrap ? '0 : row_q + cnt_w'(1));

    // Window rows top to bottom: two rows back, one row back, current pixel.
    assign new_col[0] = lb1_q[img_w-1];
    assign new_col[1] = lb0_q[img_w-1];
    assign new_col[2] = pix_in;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_FILL;
            k_q          <= '0;
            row_q        <= '0;
            col_q        <= '0;
            win_row_q    <= '0;
            win_col_q    <= '0;
            last_q       <= 1'b0;
            pix_ready_q  <= 1'b0;
            frame_done_q <= 1'b0;
            bias_q       <= '0;
            for (int i = 0; i < img_w; i++) begin
                lb0_q[i] <= '0;
                lb1_q[i] <= '0;
            end
            for (int i = 0; i < filter_size; i++) begin
                win_q[i] <= '0;
                w_q[i]   <= '0;
            end
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                S_FILL: begin
                    pix_ready_q <= 1'b1;
                    // Weights only change between bursts so a burst never mixes sets.
                    if (w_wr_en) begin
                        if (w_addr < 4'd9)
                            w_q[w_addr] <= w_data[bits-1:0];
                        else if (w_addr == 4'd9)
                            bias_q <= w_data;
                    end
                    if (accept) begin
                        lb0_q[0] <= pix_in;
                        lb1_q[0] <= lb0_q[img_w-1];
                        for (int i = 1; i < img_w; i++) begin
                            lb0_q[i] <= lb0_q[i-1];
                            lb1_q[i] <= lb1_q[i-1];
                        end
                        for (int r = 0; r < 3; r++) begin
                            win_q[3*r]   <= win_q[3*r+1];
                            win_q[3*r+1] <= win_q[3*r+2];
                            win_q[3*r+2] <= new_col[r];
                        end
                        row_q <= row_d;
                        col_q <= col_d;
                        if (win_done) begin
                            win_row_q   <= row_q - cnt_w'(2);
                            win_col_q   <= col_q - cnt_w'(2);
                            last_q      <= row_wrap && col_wrap;
                            k_q         <= '0;
                            pix_ready_q <= 1'b0;
                            state_q     <= S_EMIT;
                        end
                    end
                end
                S_EMIT: begin
                    if (k_q == 4'd8)
                        state_q <= S_WAIT;
                    else
                        k_q <= k_q + 4'd1;
                end
                S_WAIT: begin
                    if (conv_ready) begin
                        if (last_q) begin
                            frame_done_q <= 1'b1;
                            row_q        <= '0;
                            col_q        <= '0;
                            last_q       <= 1'b0;
                        end
                        pix_ready_q <= 1'b1;
                        state_q     <= S_FILL;
                    end
                end
                default: state_q <= S_FILL;
            endcase
        end
    end

    assign pix_ready   = pix_ready_q;
    assign frame_done  = frame_done_q;
    assign win_row     = win_row_q;
    assign win_col     = win_col_q;
    assign conv_bias   = bias_q;
    assign conv_start  = (state_q == S_EMIT) && (k_q == 4'd0);
    assign conv_data   = (state_q == S_EMIT) ? win_q[k_q] : '0;
    assign conv_weight = (state_q == S_EMIT) ? w_q[k_q] : '0;
endmodule
